// File: rtl/digit_frame_loader.sv
// digit_frame_loader
//   Packs an 8-bit raster pixel stream into a ping-pong pair of frame banks
//   for the classifier. One bank fills while the classifier reads the other.
//   The classifier releases a bank by writing zero to its input_valid flag.
//
// Ports
//   clk, reset                          clock; synchronous active-high reset
//   s_pixel_data/valid/last/ready       pixel stream, valid/ready handshake
//   classifier_input_address_a          read address into the current read bank
//   classifier_input_read_data_a        {zeros, pixel}, one cycle after the address
//   classifier_input_valid_read_data    {7'b0, read bank full}
//   classifier_input_valid_write_en/_data  flag write; zero releases the read bank
//   frame_count                         completed frames, wrapping
//   frame_error                         one-cycle pulse on a framing error
//
// Bank bookkeeping
//   full[b]  | meaning
//   0        | bank b is empty or being filled
//   1        | bank b holds a complete frame awaiting release
module digit_frame_loader #(
  parameter int PIXELS = 784,
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  s_pixel_data,
  input  logic              s_pixel_valid,
  input  logic              s_pixel_last,
  output logic              s_pixel_ready,
  input  logic [ADDR_W-1:0] classifier_input_address_a,
  output logic [15:0]       classifier_input_read_data_a,
  output logic [7:0]        classifier_input_valid_read_data,
  input  logic              classifier_input_valid_write_en,
  input  logic [7:0]        classifier_input_valid_write_data,
  output logic [15:0]       frame_count,
  output logic              frame_error
);

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_sel;
  logic              rd_sel;
  logic [ADDR_W-1:0] wr_cnt;

  logic [PIX_W-1:0]  bank0 [PIXELS];
  logic [PIX_W-1:0]  bank1 [PIXELS];
  logic [PIX_W-1:0]  rd_pix;

  logic accept;
  logic at_end;
  logic complete;
  logic bank_release;
  logic addr_ok;

  assign s_pixel_ready = ~reset & ~full[wr_sel];
  assign accept        = s_pixel_valid & s_pixel_ready;
  assign at_end        = (wr_cnt == ADDR_W'(PIXELS - 1));
  assign complete      = accept & at_end;
  assign bank_release  = classifier_input_valid_write_en &
                         (classifier_input_valid_write_data == 8'h00) &
                         full[rd_sel];
  assign addr_ok       = (32'(classifier_input_address_a) < PIXELS);

  assign classifier_input_valid_read_data = {7'b0, full[rd_sel]};

  // Release is applied first so that completion wins if both ever hit the
  // same bank (they cannot: completion needs the bank empty, release full).
  always_comb begin
    full_nxt = full;
    if (bank_release) full_nxt[rd_sel] = 1'b0;
    if (complete)     full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full        <= 2'b00;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      wr_cnt      <= '0;
      frame_count <= 16'd0;
      frame_error <= 1'b0;
    end else begin
      full <= full_nxt;
      if (bank_release) rd_sel <= ~rd_sel;
      // Error on a missing last at the end, or a last before the end.
      frame_error <= accept & (at_end ^ s_pixel_last);
      if (accept) begin
        if (at_end) begin
          wr_sel      <= ~wr_sel;
          wr_cnt      <= '0;
          frame_count <= frame_count + 16'd1;
        end else if (s_pixel_last) begin
          wr_cnt <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // Bank storage is not reset; contents are only meaningful while full.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_sel) bank1[wr_cnt] <= s_pixel_data;
      else        bank0[wr_cnt] <= s_pixel_data;
    end
  end

  always_comb begin
    rd_pix = '0;
    if (addr_ok) begin
      rd_pix = rd_sel ? bank1[classifier_input_address_a]
                      : bank0[classifier_input_address_a];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) classifier_input_read_data_a <= 16'd0;
    else       classifier_input_read_data_a <= {{(16-PIX_W){1'b0}}, rd_pix};
  end

endmodule

// File: tb/tb_digit_frame_loader.sv
module tb_digit_frame_loader;
  localparam int PIXELS = 784;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_pixel_data;
  logic        s_pixel_valid;
  logic        s_pixel_last;
  logic        s_pixel_ready;
  logic [9:0]  addr;
  logic [15:0] rd_data;
  logic [7:0]  vrd;
  logic        wen;
  logic [7:0]  wdata;
  logic [15:0] fcount;
  logic        ferr;

  always #5 clk = ~clk;

  digit_frame_loader dut (
    .clk                               (clk),
    .reset                             (reset),
    .s_pixel_data                      (s_pixel_data),
    .s_pixel_valid                     (s_pixel_valid),
    .s_pixel_last                      (s_pixel_last),
    .s_pixel_ready                     (s_pixel_ready),
    .classifier_input_address_a        (addr),
    .classifier_input_read_data_a      (rd_data),
    .classifier_input_valid_read_data  (vrd),
    .classifier_input_valid_write_en   (wen),
    .classifier_input_valid_write_data (wdata),
    .frame_count                       (fcount),
    .frame_error                       (ferr)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: completed frames as a flat FIFO of pixels (at most two
  // frames), plus the pixels of the frame currently being received.
  byte unsigned done_q[$];
  byte unsigned part_q[$];
  logic [15:0]  m_count = 16'd0;
  logic         m_err = 1'b0;
  logic         rd_known = 1'b0;
  logic [15:0]  rd_exp = 16'd0;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check combinational outputs, advance the model, clock the DUT,
  // then check registered outputs.
  task automatic step();
    bit ready_e, acc, rel;
    #1;
    ready_e = !reset && (done_q.size() < 2 * PIXELS);
    check("ready", {31'b0, s_pixel_ready}, {31'b0, ready_e});
    check("valid_flag", {24'b0, vrd}, {31'b0, done_q.size() > 0});
    if (reset) begin
      done_q.delete();
      part_q.delete();
      m_count  = 16'd0;
      m_err    = 1'b0;
      rd_known = 1'b1;
      rd_exp   = 16'd0;
    end else begin
      rd_known = 1'b1;
      if (addr >= PIXELS)         rd_exp = 16'd0;
      else if (done_q.size() > 0) rd_exp = {8'h00, done_q[addr]};
      else                        rd_known = 1'b0;
      acc   = s_pixel_valid && ready_e;
      rel   = wen && (wdata == 8'h00) && (done_q.size() > 0);
      m_err = 1'b0;
      if (rel) repeat (PIXELS) void'(done_q.pop_front());
      if (acc) begin
        part_q.push_back(s_pixel_data);
        if (part_q.size() == PIXELS) begin
          foreach (part_q[i]) done_q.push_back(part_q[i]);
          part_q.delete();
          m_count = m_count + 16'd1;
          m_err   = !s_pixel_last;
        end else if (s_pixel_last) begin
          part_q.delete();
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("frame_count", {16'b0, fcount}, {16'b0, m_count});
    check("frame_error", {31'b0, ferr}, {31'b0, m_err});
    if (rd_known) check("read_data", {16'b0, rd_data}, {16'b0, rd_exp});
  endtask

  task automatic idle_inputs();
    s_pixel_valid = 1'b0;
    s_pixel_last  = 1'b0;
    s_pixel_data  = 8'h00;
    wen           = 1'b0;
    wdata         = 8'h00;
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic last);
    s_pixel_valid = 1'b1;
    s_pixel_data  = d;
    s_pixel_last  = last;
    step();
    s_pixel_valid = 1'b0;
    s_pixel_last  = 1'b0;
  endtask

  // mode 0: pixel i%256; otherwise constant value.
  task automatic send_frame(input int n, input bit use_const, input logic [7:0] cval);
    for (int i = 0; i < n; i++)
      send_pixel(use_const ? cval : 8'(i), i == PIXELS - 1);
  endtask

  task automatic release_write(input logic [7:0] v);
    wen   = 1'b1;
    wdata = v;
    step();
    wen   = 1'b0;
    wdata = 8'h00;
  endtask

  initial begin
    vecs[0] = '{10'd0,    16'h0000};
    vecs[1] = '{10'd5,    16'h0005};
    vecs[2] = '{10'd255,  16'h00FF};
    vecs[3] = '{10'd256,  16'h0000};
    vecs[4] = '{10'd500,  16'h00F4};
    vecs[5] = '{10'd783,  16'h000F};
    vecs[6] = '{10'd784,  16'h0000};
    vecs[7] = '{10'd1023, 16'h0000};

    addr = 10'd0;
    reset = 1'b1;
    idle_inputs();

    // T1 reset
    do_reset(2);
    check("t1_count", {16'b0, fcount}, 32'd0);
    check("t1_rdata", {16'b0, rd_data}, 32'd0);
    #1;
    check("t1_ready_after", {31'b0, s_pixel_ready}, 32'd1);

    // T2 one frame, then table of read addresses
    send_frame(PIXELS, 1'b0, 8'h00);
    check("t2_valid", {24'b0, vrd}, 32'h01);
    check("t2_count", {16'b0, fcount}, 32'd1);
    foreach (vecs[i]) begin
      addr = vecs[i].addr;
      step();
      check("t2_rd_table", {16'b0, rd_data}, {16'b0, vecs[i].exp});
    end
    addr = 10'd0;

    // T3 back-pressure
    do_reset(1);
    send_frame(PIXELS, 1'b1, 8'h11);
    send_frame(PIXELS, 1'b1, 8'h22);
    #1;
    check("t3_ready_low", {31'b0, s_pixel_ready}, 32'd0);
    for (int i = 0; i < 5; i++) send_pixel(8'h33, 1'b0);
    release_write(8'h00);
    #1;
    check("t3_ready_back", {31'b0, s_pixel_ready}, 32'd1);
    addr = 10'd0;
    step();
    check("t3_read22", {16'b0, rd_data}, 32'h0022);
    send_frame(PIXELS, 1'b1, 8'h33);
    check("t3_count", {16'b0, fcount}, 32'd3);

    // T4 early last
    do_reset(1);
    for (int i = 0; i < 100; i++) send_pixel(8'(i), i == 99);
    check("t4_err_pulse", {31'b0, ferr}, 32'd1);
    step();
    check("t4_err_clear", {31'b0, ferr}, 32'd0);
    check("t4_valid", {24'b0, vrd}, 32'h00);
    check("t4_count", {16'b0, fcount}, 32'd0);
    send_frame(PIXELS, 1'b0, 8'h00);
    check("t4_valid_after", {24'b0, vrd}, 32'h01);

    // T5 completion and release in the same cycle
    do_reset(1);
    send_frame(PIXELS, 1'b1, 8'hA5);
    for (int i = 0; i < PIXELS - 1; i++) send_pixel(8'h5A, 1'b0);
    wen   = 1'b1;
    wdata = 8'h00;
    send_pixel(8'h5A, 1'b1);
    wen   = 1'b0;
    check("t5_valid", {24'b0, vrd}, 32'h01);
    check("t5_count", {16'b0, fcount}, 32'd2);
    #1;
    check("t5_ready", {31'b0, s_pixel_ready}, 32'd1);
    addr = 10'd0;
    step();
    check("t5_rd_bank1", {16'b0, rd_data}, 32'h005A);

    // T6 reset mid-fill
    do_reset(1);
    for (int i = 0; i < 400; i++) send_pixel(8'hC3, 1'b0);
    do_reset(1);
    check("t6_valid0", {24'b0, vrd}, 32'h00);
    for (int i = 0; i < PIXELS - 1; i++) send_pixel(8'(i + 7), 1'b0);
    check("t6_valid_not_yet", {24'b0, vrd}, 32'h00);
    send_pixel(8'h99, 1'b1);
    check("t6_valid1", {24'b0, vrd}, 32'h01);
    release_write(8'h01);
    check("t6_nonzero_ignored", {24'b0, vrd}, 32'h01);
    addr = 10'd0;
    step();
    check("t6_rd0", {16'b0, rd_data}, 32'h0007);

    // Randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      reset         = ($urandom_range(2999) == 0);
      s_pixel_valid = ($urandom_range(3) != 0);
      s_pixel_data  = 8'($urandom);
      if (part_q.size() == PIXELS - 1) s_pixel_last = ($urandom_range(9) != 0);
      else                             s_pixel_last = ($urandom_range(399) == 0);
      wen   = ($urandom_range(29) == 0);
      wdata = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      addr  = ($urandom_range(9) == 0) ? 10'($urandom) : 10'($urandom_range(PIXELS - 1));
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
